// File: rtl/lcd_text_driver.sv
// lcd_text_driver: pulls ASCII characters from a character source and drives
// an HD44780-compatible 2x16 text LCD over its 8-bit parallel bus.
// After reset it waits, sends the init command sequence, clears the display,
// then refreshes line 1 and line 2 forever.
// Optional build macro: LCD_CURSOR_BLINK_EN turns the cursor and blink on
// (display-on command 8'h0F instead of 8'h0C).
module lcd_text_driver #(
    parameter int INIT_DELAY     = 70,
    parameter int STEP_CYCLES    = 3,
    parameter int CLEAR_WAIT     = 20,
    parameter int CHARS_PER_LINE = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] CHAR_DATA,
    output logic       CHAR_ADV,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       LINE_SEL
);

    typedef enum logic [3:0] {
        ST_DELAY      = 4'd0,
        ST_FUNC_SET   = 4'd1,
        ST_DISP_ON    = 4'd2,
        ST_ENTRY_MODE = 4'd3,
        ST_CLEAR_DISP = 4'd4,
        ST_CLEAR_HOLD = 4'd5,
        ST_LINE1_ADDR = 4'd6,
        ST_LINE1      = 4'd7,
        ST_LINE2_ADDR = 4'd8,
        ST_LINE2      = 4'd9
    } state_t;

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_ON_CMD = 8'h0F;
`else
    localparam logic [7:0] DISP_ON_CMD = 8'h0C;
`endif

    localparam logic [7:0]  LAST_STEP    = 8'(STEP_CYCLES - 1);
    localparam logic [7:0]  LAST_CHAR    = 8'(CHARS_PER_LINE - 1);
    localparam logic [15:0] INIT_WAIT_W  = 16'(INIT_DELAY);
    localparam logic [15:0] CLEAR_WAIT_W = 16'(CLEAR_WAIT);

    // Command byte sent during each command transaction.
    function automatic logic [7:0] cmd_byte(input state_t s);
        logic [7:0] b;
        case (s)
            ST_FUNC_SET:   b = 8'h38;
            ST_DISP_ON:    b = DISP_ON_CMD;
            ST_ENTRY_MODE: b = 8'h06;
            ST_CLEAR_DISP: b = 8'h01;
            ST_LINE1_ADDR: b = 8'h80;
            ST_LINE2_ADDR: b = 8'hC0;
            default:       b = 8'h00;
        endcase
        return b;
    endfunction

    // True for the states whose transactions write character data.
    function automatic logic is_char_state(input state_t s);
        return (s == ST_LINE1) || (s == ST_LINE2);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  step_q, step_d;
    logic [15:0] wait_q, wait_d;
    logic [7:0]  idx_q, idx_d;
    logic        lcd_e_q, lcd_e_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_rw_q, lcd_rw_d;
    logic [7:0]  lcd_data_q, lcd_data_d;
    logic        char_adv_q, char_adv_d;
    logic        line_sel_q, line_sel_d;
    logic        start_s;
    state_t      start_state_s;

    // Next-state and next-output logic: steps the phase of the current
    // transaction and, when one ends, loads RS/DATA for the next one.
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        wait_d        = wait_q;
        idx_d         = idx_q;
        lcd_e_d       = 1'b0;
        lcd_rs_d      = lcd_rs_q;
        lcd_rw_d      = 1'b0;
        lcd_data_d    = lcd_data_q;
        char_adv_d    = 1'b0;
        line_sel_d    = line_sel_q;
        start_s       = 1'b0;
        start_state_s = state_q;

        case (state_q)
            ST_DELAY: begin
                if (wait_q >= INIT_WAIT_W) begin
                    start_s       = 1'b1;
                    start_state_s = ST_FUNC_SET;
                    wait_d        = 16'd0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_CLEAR_HOLD: begin
                if (wait_q >= CLEAR_WAIT_W) begin
                    start_s       = 1'b1;
                    start_state_s = ST_LINE1_ADDR;
                    wait_d        = 16'd0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: begin
                if (step_q == LAST_STEP) begin
                    case (state_q)
                        ST_FUNC_SET: begin
                            start_s       = 1'b1;
                            start_state_s = ST_DISP_ON;
                        end
                        ST_DISP_ON: begin
                            start_s       = 1'b1;
                            start_state_s = ST_ENTRY_MODE;
                        end
                        ST_ENTRY_MODE: begin
                            start_s       = 1'b1;
                            start_state_s = ST_CLEAR_DISP;
                        end
                        ST_CLEAR_DISP: begin
                            // Entering the hold already counts as its first idle clock.
                            state_d = ST_CLEAR_HOLD;
                            step_d  = 8'd0;
                            wait_d  = 16'd1;
                        end
                        ST_LINE1_ADDR: begin
                            start_s       = 1'b1;
                            start_state_s = ST_LINE1;
                        end
                        ST_LINE1: begin
                            start_s = 1'b1;
                            if (idx_q == LAST_CHAR) begin
                                idx_d         = 8'd0;
                                start_state_s = ST_LINE2_ADDR;
                            end else begin
                                idx_d         = idx_q + 8'd1;
                                start_state_s = ST_LINE1;
                            end
                        end
                        ST_LINE2_ADDR: begin
                            start_s       = 1'b1;
                            start_state_s = ST_LINE2;
                        end
                        ST_LINE2: begin
                            start_s = 1'b1;
                            if (idx_q == LAST_CHAR) begin
                                idx_d         = 8'd0;
                                start_state_s = ST_LINE1_ADDR;
                            end else begin
                                idx_d         = idx_q + 8'd1;
                                start_state_s = ST_LINE2;
                            end
                        end
                        default: begin
                            // Unreachable encoding: restart the whole init sequence.
                            state_d = ST_DELAY;
                            step_d  = 8'd0;
                            wait_d  = 16'd0;
                            idx_d   = 8'd0;
                        end
                    endcase
                end else begin
                    step_d     = step_q + 8'd1;
                    lcd_e_d    = (step_q == 8'd0);
                    char_adv_d = is_char_state(state_q) && ((step_q + 8'd1) == LAST_STEP);
                end
            end
        endcase

        if (start_s) begin
            state_d = start_state_s;
            step_d  = 8'd0;
            if (is_char_state(start_state_s)) begin
                lcd_rs_d   = 1'b1;
                lcd_data_d = CHAR_DATA;
            end else begin
                lcd_rs_d   = 1'b0;
                lcd_data_d = cmd_byte(start_state_s);
            end
            if (start_state_s == ST_LINE2_ADDR) begin
                line_sel_d = 1'b1;
            end else if (start_state_s == ST_LINE1_ADDR) begin
                line_sel_d = 1'b0;
            end else begin
                line_sel_d = line_sel_q;
            end
        end else begin
            line_sel_d = line_sel_q;
        end
    end

    // State, counters and registered outputs; reset forces everything idle.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= ST_DELAY;
            step_q     <= 8'd0;
            wait_q     <= 16'd0;
            idx_q      <= 8'd0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_rw_q   <= 1'b0;
            lcd_data_q <= 8'h00;
            char_adv_q <= 1'b0;
            line_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_rw_q   <= lcd_rw_d;
            lcd_data_q <= lcd_data_d;
            char_adv_q <= char_adv_d;
            line_sel_q <= line_sel_d;
        end
    end

    assign LCD_E    = lcd_e_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_RW   = lcd_rw_q;
    assign LCD_DATA = lcd_data_q;
    assign CHAR_ADV = char_adv_q;
    assign LINE_SEL = line_sel_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Testbench for lcd_text_driver: random character source advanced by CHAR_ADV,
// checked against a transaction-level model of the expected LCD bus traffic.
module tb_lcd_text_driver;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] char_data;
    logic       char_adv;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       line_sel;

    always #5 clk = ~clk;

    lcd_text_driver dut (
        .CLK       (clk),
        .RESETN    (resetn),
        .CHAR_DATA (char_data),
        .CHAR_ADV  (char_adv),
        .LCD_E     (lcd_e),
        .LCD_RS    (lcd_rs),
        .LCD_RW    (lcd_rw),
        .LCD_DATA  (lcd_data),
        .LINE_SEL  (line_sel)
    );

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_EXP = 8'h0F;
`else
    localparam logic [7:0] DISP_EXP = 8'h0C;
`endif

    int checks   = 0;
    int failures = 0;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Clock edges since reset release; the first edge with RESETN=1 is cycle 0.
    int since_rst = 0;
    always @(posedge clk) since_rst <= resetn ? since_rst + 1 : 0;

    logic [7:0] src_mem [256];
    logic [7:0] init_cmd [4];
    int         ptr;
    int         n_pulse;
    int         n_data;
    int         adv_cnt;
    int         exp_e_cyc;
    int         last_data_e;
    logic       prev_e;
    logic [7:0] prev_data;
    logic [7:0] data_at_e;
    logic       rs_at_e;

    // Expected contents of E pulse number n, given nd data pulses seen so far.
    task automatic expect_pulse(input int n, input int nd,
                                output logic rs, output logic [7:0] d, output logic ls);
        int p;
        if (n < 4) begin
            rs = 1'b0; d = init_cmd[n]; ls = 1'b0;
        end else begin
            p = (n - 4) % 34;
            if (p == 0) begin
                rs = 1'b0; d = 8'h80; ls = 1'b0;
            end else if (p <= 16) begin
                rs = 1'b1; d = src_mem[nd % 256]; ls = 1'b0;
            end else if (p == 17) begin
                rs = 1'b0; d = 8'hC0; ls = 1'b1;
            end else begin
                rs = 1'b1; d = src_mem[nd % 256]; ls = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        n_pulse     = 0;
        n_data      = 0;
        adv_cnt     = 0;
        ptr         = 0;
        exp_e_cyc   = 71;
        last_data_e = -100;
        prev_e      = 1'b0;
        prev_data   = 8'h00;
        char_data   = src_mem[0];
    endtask

    // One clock: observe at the falling edge, update the model and the source.
    task automatic step_cycle();
        int         cyc;
        logic       rs_x;
        logic [7:0] d_x;
        logic       ls_x;
        @(negedge clk);
        cyc = since_rst - 1;
        if (char_adv) begin
            check_eq("adv_timing", cyc, last_data_e + 1);
            adv_cnt++;
            ptr++;
        end
        if (prev_e) begin
            check_eq("e_width", lcd_e, 1'b0);
            check_eq("data_hold", lcd_data, data_at_e);
            check_eq("rs_hold", lcd_rs, rs_at_e);
        end else if (lcd_e) begin
            expect_pulse(n_pulse, n_data, rs_x, d_x, ls_x);
            check_eq("e_cycle", cyc, exp_e_cyc);
            check_eq("rs", lcd_rs, rs_x);
            check_eq("data", lcd_data, d_x);
            check_eq("data_setup", lcd_data, prev_data);
            check_eq("line_sel", line_sel, ls_x);
            check_eq("rw", lcd_rw, 1'b0);
            check_eq("adv_count", adv_cnt, n_data);
            if (rs_x) begin
                last_data_e = cyc;
                n_data++;
            end
            exp_e_cyc += (n_pulse == 3) ? 23 : 3;
            n_pulse++;
            data_at_e = lcd_data;
            rs_at_e   = lcd_rs;
        end
        prev_e    = lcd_e;
        prev_data = lcd_data;
        char_data = src_mem[ptr % 256];
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom_range(0, 255));
        init_cmd[0] = 8'h38;
        init_cmd[1] = DISP_EXP;
        init_cmd[2] = 8'h06;
        init_cmd[3] = 8'h01;
        resetn = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_eq("rst_e", lcd_e, 1'b0);
        check_eq("rst_rs", lcd_rs, 1'b0);
        check_eq("rst_rw", lcd_rw, 1'b0);
        check_eq("rst_data", lcd_data, 8'h00);
        check_eq("rst_adv", char_adv, 1'b0);
        check_eq("rst_line_sel", line_sel, 1'b0);
        resetn = 1'b1;

        // Init, two full frames and the wrap back to line 1.
        for (int c = 0; c < 4000 && n_pulse < 73; c++) step_cycle();
        check_eq("frames_done", n_pulse, 73);
        check_eq("adv_per_two_frames", adv_cnt, 64);

        // Advance to phase 1 of line-1 character 7, then reset for one clock.
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            step_cycle();
            if (lcd_e && n_pulse > 4 && ((n_pulse - 5) % 34) == 8) hit = 1'b1;
        end
        check_eq("mid_reset_reached", hit, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_e", lcd_e, 1'b0);
        check_eq("mid_rst_data", lcd_data, 8'h00);
        check_eq("mid_rst_rs", lcd_rs, 1'b0);
        check_eq("mid_rst_adv", char_adv, 1'b0);
        check_eq("mid_rst_line_sel", line_sel, 1'b0);
        model_reset();
        resetn = 1'b1;

        // Full re-init after the mid-operation reset.
        for (int c = 0; c < 500 && n_pulse < 8; c++) step_cycle();
        check_eq("reinit_done", n_pulse, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
